auth_msg_assembler: RTL and testbench
=====================================

Name: auth_msg_assembler

Overview:
- Receive-side stage directly upstream of the authentication controller's auth_msg_in input.
- Collects a byte stream from the PD/DEBUG transport, left-packs it into one MSG_LEN-bit authentication message and validates the 4-byte header.
- Presents the message to the controller with a valid/ack handshake, and back-pressures the byte source while a message is outstanding.

Parameters:
- MSG_LEN, 2080, message width in bits; must be a multiple of 8; defaults to the codebase MSG_LEN value.
- MSG_BYTES, MSG_LEN/8 (260), maximum message length in bytes.
- PROTO_VER, 8'h01, required value of header byte 0.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming message byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_last  input  1  qualifies byte_in as the final byte of a message; ignored unless byte_valid=1.
- byte_ready  output  1  assembler accepts a byte this cycle.
- auth_msg_in  output  MSG_LEN  assembled message; byte 0 in bits [MSG_LEN-1:MSG_LEN-8].
- auth_msg_valid  output  1  auth_msg_in is complete and header-valid.
- auth_msg_ack  input  1  controller has consumed the message.
- msg_len  output  9  number of bytes in the held message (4..MSG_BYTES).
- err_hdr  output  1  one-cycle pulse: bad protocol version, bad message type, or message shorter than 4 bytes.
- err_ovf  output  1  one-cycle pulse: more than MSG_BYTES bytes were received before byte_last.

Behaviour:
- Reset values: all outputs 0 except byte_ready=1. auth_msg_in is cleared to all zeros, byte counter is 0, state is IDLE.
- A byte is accepted only in a cycle where byte_valid=1 and byte_ready=1.
- States:
  - IDLE / COLLECT: byte_ready=1.
    - IDLE: on the first accepted byte, clear the shadow buffer, store the byte at index 0, set count=1, go to COLLECT. If byte_last is also set, evaluate immediately (count=1, which is too short → err_hdr).
    - COLLECT: each accepted byte is stored at index count, then count increments.
    - Byte index i occupies bits [MSG_LEN-1-8i -: 8]. Unwritten bytes stay 0.
  - On an accepted byte with byte_last=1, the message is evaluated with final length N = count+1:
    - N<4, byte0!=PROTO_VER, or byte1 not in {8'h81, 8'h82, 8'h83}: pulse err_hdr for one cycle, return to IDLE, auth_msg_valid stays 0.
    - Otherwise: in the next cycle copy the shadow buffer to auth_msg_in, set msg_len=N and auth_msg_valid=1, go to HOLD. Valid is asserted 1 cycle after the last byte is accepted.
  - Overflow: an accepted byte with count==MSG_BYTES and byte_last=0 pulses err_ovf and moves to DRAIN.
    - A byte_last arriving exactly at byte MSG_BYTES is legal (full-length message).
  - DRAIN: byte_ready=1. Bytes are discarded; the first accepted byte_last returns to IDLE. No output is produced.
  - HOLD: byte_ready=0. auth_msg_in and msg_len are stable.
    - auth_msg_ack=1 clears auth_msg_valid next cycle and returns to IDLE. byte_ready rises in that same next cycle.
    - auth_msg_ack outside HOLD is ignored.
- Back-to-back operation: the minimum gap between the ack cycle and the first byte of the next message is 1 cycle. No byte is lost because byte_ready=0 throughout HOLD.
- A reset asserted mid-message or in HOLD aborts everything: outputs return to reset values in the following cycle, and no err pulse is generated.
- err_hdr and err_ovf never assert in the same cycle, and never assert together with auth_msg_valid rising.

Test Plan:
- Send 6 bytes 01 82 00 00 00 00 (last on byte 6), then ack 3 cycles after valid:
  - auth_msg_valid rises 1 cycle after byte 6; msg_len=6.
  - auth_msg_in[2079:2048]=32'h01820000, rest 0.
  - byte_ready=0 until the cycle after ack.
- Full-length 260-byte message with header 01 83, bytes 4..259 = index mod 256:
  - valid=1, msg_len=260, auth_msg_in[7:0]=8'h03.
- Header 02 82 00 00: err_hdr pulses 1 cycle, no valid. Then send 3 bytes 01 81 00: err_hdr again (too short).
- 262 bytes without last, then a last byte:
  - err_ovf pulses on byte 261; bytes are discarded until last.
  - A following valid 4-byte message 01 81 00 00 is accepted correctly.
- Valid message, then hold off ack for 20 cycles while the source keeps byte_valid=1:
  - no byte is accepted and auth_msg_in is stable.
  - After ack, the next message is received intact.
- Assert reset during byte 3 of a message: all outputs at reset values next cycle; a subsequent valid message assembles correctly.

Source files
------------

// File: rtl/auth_msg_assembler.sv
// auth_msg_assembler: collects a byte stream into one left-packed MSG_LEN-bit
// authentication message, validates its 4-byte header and hands it to the
// authentication controller with a valid/ack handshake.
module auth_msg_assembler #(
  parameter int          MSG_LEN   = 2080,
  parameter logic [7:0]  PROTO_VER = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic [MSG_LEN-1:0] auth_msg_in,
  output logic               auth_msg_valid,
  input  logic               auth_msg_ack,
  output logic [8:0]         msg_len,
  output logic               err_hdr,
  output logic               err_ovf
);

  localparam int MSG_BYTES = MSG_LEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         count_q, count_d;
  logic [MSG_LEN-1:0] shadow_q, shadow_d;
  logic [8:0]         len_d;
  logic               load_msg, clr_valid;
  logic               err_hdr_d, err_ovf_d;
  logic               accept;
  logic [8:0]         idx;
  logic [7:0]         hdr_b0, hdr_b1;
  logic               hdr_ok;

  assign byte_ready = (state_q != S_HOLD);
  assign accept     = byte_valid && byte_ready;

  // Next-state, shadow-buffer write and one-cycle event decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    shadow_d  = shadow_q;
    len_d     = '0;
    load_msg  = 1'b0;
    clr_valid = 1'b0;
    err_hdr_d = 1'b0;
    err_ovf_d = 1'b0;
    idx       = (state_q == S_IDLE) ? 9'd0 : count_q;
    hdr_b0    = '0;
    hdr_b1    = '0;
    hdr_ok    = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          if (state_q == S_COLLECT && count_q == 9'(MSG_BYTES)) begin
            // Buffer already full and another byte arrived: overflow.
            err_ovf_d = 1'b1;
            count_d   = '0;
            state_d   = byte_last ? S_IDLE : S_DRAIN;
          end else begin
            if (state_q == S_IDLE) shadow_d = '0;
            shadow_d[MSG_LEN-1-8*int'(idx) -: 8] = byte_in;
            count_d = idx + 9'd1;
            state_d = S_COLLECT;
            if (byte_last) begin
              len_d   = idx + 9'd1;
              hdr_b0  = shadow_d[MSG_LEN-1 -: 8];
              hdr_b1  = shadow_d[MSG_LEN-9 -: 8];
              hdr_ok  = (len_d >= 9'd4) && (hdr_b0 == PROTO_VER) &&
                        (hdr_b1 == 8'h81 || hdr_b1 == 8'h82 || hdr_b1 == 8'h83);
              count_d = '0;
              if (hdr_ok) begin
                load_msg = 1'b1;
                state_d  = S_HOLD;
              end else begin
                err_hdr_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (accept && byte_last) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (auth_msg_ack) begin
          clr_valid = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, output message register and error pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      auth_msg_in    <= '0;
      auth_msg_valid <= 1'b0;
      msg_len        <= '0;
      err_hdr        <= 1'b0;
      err_ovf        <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_hdr <= err_hdr_d;
      err_ovf <= err_ovf_d;
      if (load_msg) begin
        auth_msg_in    <= shadow_d;
        msg_len        <= len_d;
        auth_msg_valid <= 1'b1;
      end else if (clr_valid) begin
        auth_msg_valid <= 1'b0;
      end
    end
  end

  // Shadow buffer capture.
  always_ff @(posedge clk) begin
    // NOTE: the shadow buffer has no reset; it is zeroed on the first byte of
    // every message, so its contents before that are never observed.
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_auth_msg_assembler.sv
// Self-checking bench for auth_msg_assembler: directed scenarios plus random
// messages, compared against a message-level reference model.
module tb_auth_msg_assembler;

  localparam int MSG_LEN   = 2080;
  localparam int MSG_BYTES = MSG_LEN / 8;

  typedef logic [7:0] byte_q_t[$];

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_last;
  logic               byte_ready;
  logic [MSG_LEN-1:0] auth_msg_in;
  logic               auth_msg_valid;
  logic               auth_msg_ack;
  logic [8:0]         msg_len;
  logic               err_hdr;
  logic               err_ovf;

  int checks = 0;
  int errors = 0;

  auth_msg_assembler #(.MSG_LEN(MSG_LEN), .PROTO_VER(8'h01)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_last      (byte_last),
    .byte_ready     (byte_ready),
    .auth_msg_in    (auth_msg_in),
    .auth_msg_valid (auth_msg_valid),
    .auth_msg_ack   (auth_msg_ack),
    .msg_len        (msg_len),
    .err_hdr        (err_hdr),
    .err_ovf        (err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected message image: byte i at bits [MSG_LEN-1-8i -: 8], rest zero.
  function automatic logic [MSG_LEN-1:0] pack(input byte_q_t q);
    logic [MSG_LEN-1:0] v = '0;
    for (int i = 0; i < q.size() && i < MSG_BYTES; i++) v[MSG_LEN-1-8*i -: 8] = q[i];
    return v;
  endfunction

  // Compare the message word by word; report the first differing 32-bit word.
  task automatic check_msg(input string tag, input logic [MSG_LEN-1:0] exp);
    int w = 0;
    for (int i = 0; i < MSG_LEN/32; i++) begin
      if (auth_msg_in[MSG_LEN-1-32*i -: 32] !== exp[MSG_LEN-1-32*i -: 32]) begin
        w = i;
        break;
      end
    end
    check(tag, 64'(auth_msg_in[MSG_LEN-1-32*w -: 32]), 64'(exp[MSG_LEN-1-32*w -: 32]));
  endtask

  // Outcome per the header/length rules: 0 = valid, 1 = header error, 2 = overflow.
  function automatic int outcome(input byte_q_t q);
    if (q.size() > MSG_BYTES) return 2;
    if (q.size() < 4) return 1;
    if (q[0] != 8'h01) return 1;
    if (!(q[1] inside {8'h81, 8'h82, 8'h83})) return 1;
    return 0;
  endfunction

  // Drive one message, check the result, and ack after hold_cycles.
  task automatic send(input byte_q_t q, input int hold_cycles, input bit stuff_hold);
    int n = q.size();
    int kind = outcome(q);
    logic [MSG_LEN-1:0] exp = pack(q);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        byte_valid = 1'b0;
        step();
      end
      byte_in    = q[i];
      byte_valid = 1'b1;
      byte_last  = (i == n - 1);
      step();
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      if (i == MSG_BYTES || err_ovf) check("err_ovf", 64'(err_ovf), 64'(i == MSG_BYTES));
    end
    case (kind)
      0: begin
        check("valid", 64'(auth_msg_valid), 64'd1);
        check("msg_len", 64'(msg_len), 64'(n));
        check_msg("msg", exp);
        check("no_err_hdr", 64'(err_hdr), 64'd0);
        check("ready_hold", 64'(byte_ready), 64'd0);
        for (int c = 0; c < hold_cycles; c++) begin
          if (stuff_hold) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            byte_last  = 1'($urandom);
          end
          step();
          if (stuff_hold || c == hold_cycles - 1) begin
            check("ready_hold", 64'(byte_ready), 64'd0);
            check("valid_hold", 64'(auth_msg_valid), 64'd1);
          end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        check_msg("msg_stable", exp);
        check("len_stable", 64'(msg_len), 64'(n));
        auth_msg_ack = 1'b1;
        step();
        auth_msg_ack = 1'b0;
        check("valid_clr", 64'(auth_msg_valid), 64'd0);
        check("ready_ack", 64'(byte_ready), 64'd1);
      end
      1: begin
        check("err_hdr", 64'(err_hdr), 64'd1);
        check("no_valid", 64'(auth_msg_valid), 64'd0);
        step();
        check("err_hdr_pulse", 64'(err_hdr), 64'd0);
      end
      default: begin
        check("ovf_no_hdr", 64'(err_hdr), 64'd0);
        check("ovf_no_valid", 64'(auth_msg_valid), 64'd0);
        check("ovf_ready", 64'(byte_ready), 64'd1);
      end
    endcase
  endtask

  initial begin
    byte_q_t q;
    reset        = 1'b1;
    byte_in      = '0;
    byte_valid   = 1'b0;
    byte_last    = 1'b0;
    auth_msg_ack = 1'b0;
    step();
    step();
    check("rst_ready", 64'(byte_ready), 64'd1);
    check("rst_valid", 64'(auth_msg_valid), 64'd0);
    check("rst_len", 64'(msg_len), 64'd0);
    check("rst_errs", {62'd0, err_hdr, err_ovf}, 64'd0);
    check_msg("rst_msg", '0);
    reset = 1'b0;
    step();

    // Six-byte message, ack three cycles after valid.
    q = '{8'h01, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00};
    send(q, 2, 1'b0);
    check("hdr_word", 64'(auth_msg_in[2079:2048]), 64'h01820000);

    // Full-length message.
    q = '{8'h01, 8'h83, 8'h00, 8'h00};
    for (int i = 4; i < MSG_BYTES; i++) q.push_back(8'(i));
    send(q, 1, 1'b0);
    check("full_lsb", 64'(auth_msg_in[7:0]), 64'h03);

    // Bad version, then too short.
    q = '{8'h02, 8'h82, 8'h00, 8'h00};
    send(q, 0, 1'b0);
    q = '{8'h01, 8'h81, 8'h00};
    send(q, 0, 1'b0);

    // Overflow: 262 bytes without last, then a last byte; then a good message.
    q = {};
    for (int i = 0; i < MSG_BYTES + 3; i++) q.push_back(8'($urandom));
    send(q, 0, 1'b0);
    q = '{8'h01, 8'h81, 8'h00, 8'h00};
    send(q, 0, 1'b0);

    // Ack withheld 20 cycles while the source keeps pushing; next message intact.
    q = '{8'h01, 8'h82, 8'hde, 8'had, 8'hbe, 8'hef};
    send(q, 20, 1'b1);
    q = '{8'h01, 8'h83, 8'h11, 8'h22, 8'h33};
    send(q, 0, 1'b0);

    // Reset during byte 3 of a message.
    byte_valid = 1'b1;
    byte_in    = 8'h01; step();
    byte_in    = 8'h82; step();
    byte_in    = 8'h55;
    reset      = 1'b1;
    step();
    byte_valid = 1'b0;
    reset      = 1'b0;
    check("mid_rst_ready", 64'(byte_ready), 64'd1);
    check("mid_rst_valid", 64'(auth_msg_valid), 64'd0);
    check("mid_rst_len", 64'(msg_len), 64'd0);
    check("mid_rst_errs", {62'd0, err_hdr, err_ovf}, 64'd0);
    check_msg("mid_rst_msg", '0);
    q = '{8'h01, 8'h81, 8'h0a, 8'h0b, 8'h0c};
    send(q, 0, 1'b0);

    // Random messages.
    for (int t = 0; t < 30; t++) begin
      int n = ($urandom_range(7) == 0) ? int'($urandom_range(MSG_BYTES - 2, MSG_BYTES + 2))
                                       : int'($urandom_range(1, 10));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if ($urandom_range(3) != 0) q[0] = 8'h01;
      if (n > 1 && $urandom_range(3) != 0) q[1] = 8'(8'h81 + $urandom_range(2));
      send(q, $urandom_range(4), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
